// File: rtl/slave_bus_reader_if.sv
// Slave output bus seen from slave_bus_reader: arbitration and buffer read
// lines toward the sources, byte stream toward the host-side transmitter.
`timescale 1ns/1ps
interface slave_bus_reader_if #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned ADDR_W     = 9
);
  logic [NUM_SLAVES-1:0] sl_arb_request;
  logic [NUM_SLAVES-1:0] sl_arb_grant;
  logic [ADDR_W-1:0]     sl_addr;
  logic [ADDR_W-1:0]     sl_tail;
  logic [8:0]            sl_data;
  logic                  sl_latch_tail;
  logic [7:0]            out_data;
  logic                  out_flag;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  sl_arb_request, sl_tail, sl_data, out_ready,
    output sl_arb_grant, sl_addr, sl_latch_tail,
           out_data, out_flag, out_last, out_valid
  );

  modport slave (
    output sl_arb_request, sl_tail, sl_data, out_ready,
    input  sl_arb_grant, sl_addr, sl_latch_tail,
           out_data, out_flag, out_last, out_valid
  );
endinterface

// File: rtl/slave_bus_reader.sv
// Round-robin reader of the ICE slave output bus: grants one source, streams its
// frame out over valid/ready, then commits it. SLAVE_BUS_READER_STATS_EN adds counters.
`timescale 1ns/1ps
module slave_bus_reader #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic               clk,
  input  logic               reset,
  slave_bus_reader_if.master bus,
  output logic               busy
`ifdef SLAVE_BUS_READER_STATS_EN
  ,
  output logic [15:0]        frames_drained,
  output logic [15:0]        bytes_drained
`endif
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COMMIT  = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      g_q, g_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [ADDR_W-1:0]     tail_q, tail_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     head_q [NUM_SLAVES];
  logic [ADDR_W-1:0]     head_d [NUM_SLAVES];
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_flag_q, out_flag_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  logic [ADDR_W-1:0]     head_cur;
  logic [ADDR_W-1:0]     head_inc;
  logic                  accept;
  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;

  assign head_cur = head_q[g_q];
  assign head_inc = head_cur + ADDR_W'(1);
  assign accept   = (state_q == S_WAIT) && bus.out_ready;

  // First requester at or after rr_q, scanning with wrap-around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % NUM_SLAVES);
      if (!pick_vld && bus.sl_arb_request[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    g_d         = g_q;
    rr_d        = rr_q;
    tail_d      = tail_q;
    addr_d      = addr_q;
    head_d      = head_q;
    out_data_d  = out_data_q;
    out_flag_d  = out_flag_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          g_d               = pick_idx;
          state_d           = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        tail_d = bus.sl_tail;
        if (bus.sl_tail == head_cur) begin
          state_d = S_COMMIT;
        end else begin
          addr_d  = head_cur;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        out_data_d  = bus.sl_data[7:0];
        out_flag_d  = bus.sl_data[8];
        out_last_d  = (head_inc == tail_q);
        out_valid_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (bus.out_ready) begin
          out_valid_d  = 1'b0;
          head_d[g_q]  = head_inc;
          if (out_last_q) begin
            state_d = S_COMMIT;
          end else begin
            // sl_addr is loaded on entry to ADDR so it already shows head during ADDR
            addr_d  = head_inc;
            state_d = S_ADDR;
          end
        end
      end
      S_COMMIT: begin
        head_d[g_q] = tail_q;
        state_d     = S_RELEASE;
      end
      S_RELEASE: begin
        grant_d = '0;
        rr_d    = (g_q == IDX_W'(NUM_SLAVES - 1)) ? '0 : g_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      g_q         <= '0;
      rr_q        <= '0;
      tail_q      <= '0;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_flag_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        head_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      g_q         <= g_d;
      rr_q        <= rr_d;
      tail_q      <= tail_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_flag_q  <= out_flag_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

  assign bus.sl_arb_grant  = grant_q;
  assign bus.sl_addr       = addr_q;
  assign bus.sl_latch_tail = (state_q == S_COMMIT);
  assign bus.out_data      = out_data_q;
  assign bus.out_flag      = out_flag_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_valid     = out_valid_q;
  assign busy              = (state_q != S_IDLE);

`ifdef SLAVE_BUS_READER_STATS_EN
  logic [15:0] frames_q;
  logic [15:0] bytes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q <= '0;
      bytes_q  <= '0;
    end else begin
      if (state_q == S_COMMIT) frames_q <= frames_q + 16'd1;
      if (accept)              bytes_q  <= bytes_q + 16'd1;
    end
  end

  assign frames_drained = frames_q;
  assign bytes_drained  = bytes_q;
`endif

endmodule
